// File: rtl/sigrnd_pipe_pkg.sv
// Shared types and field-boundary constants for the significand rounding stage.
package fpu_rnd_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RZ  = 3'b001,
    RM_RU  = 3'b010,
    RM_RD  = 3'b011,
    RM_RMM = 3'b100
  } rm_t;

  localparam int unsigned SIG_W_D   = 53;
  localparam int unsigned SIG_W_S   = 24;
  localparam int unsigned EXP_MAX_D = 2047;
  localparam int unsigned EXP_MAX_S = 255;

  localparam int unsigned KEPT_LO_D = 75;
  localparam int unsigned RND_D     = 74;
  localparam int unsigned KEPT_LO_S = 104;
  localparam int unsigned RND_S     = 103;

  typedef struct packed {
    logic [SIG_W_D-1:0] kept;
    logic               inc;
    logic               inx;
    logic [10:0]        exp;
    logic               db;
    logic               tiny;
    logic               ovf1;
  } s1_t;

endpackage

// File: rtl/sigrnd_pipe_if.sv
// Valid/ready bus between normshift, the rounding stage and the packer.
interface sigrnd_pipe_if;
  import fpu_rnd_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [127:0]       fn;
  logic [10:0]        en;
  logic               s;
  logic [2:0]         rm;
  logic               db;
  logic               tiny_in;
  logic               ovf1_in;
  logic               out_valid;
  logic               out_ready;
  logic [SIG_W_D-1:0] f_out;
  logic [10:0]        e_out;
  logic               inx;
  logic               ovf2;
  logic               tiny_out;
  logic               ovf1_out;

  modport slave (
    input  in_valid, fn, en, s, rm, db, tiny_in, ovf1_in, out_ready,
    output in_ready, out_valid, f_out, e_out, inx, ovf2, tiny_out, ovf1_out
  );

  modport master (
    output in_valid, fn, en, s, rm, db, tiny_in, ovf1_in, out_ready,
    input  in_ready, out_valid, f_out, e_out, inx, ovf2, tiny_out, ovf1_out
  );

endinterface

// File: rtl/sigrnd_pipe_rnd_decide.sv
// Rounding increment / inexact decision. SIGRND_RMM_EN enables ties-away for rm=100.
module rnd_decide
  import fpu_rnd_pkg::*;
(
  input  logic lsb,
  input  logic r,
  input  logic st,
  input  logic s,
  input  rm_t  rm,
  output logic inc,
  output logic inx
);

  always_comb begin
    inx = r | st;
    case (rm)
      RM_RZ:   inc = 1'b0;
      RM_RU:   inc = ~s & (r | st);
      RM_RD:   inc = s & (r | st);
`ifdef SIGRND_RMM_EN
      RM_RMM:  inc = r;
`endif
      default: inc = r & (st | lsb);
    endcase
  end

endmodule

// File: rtl/sigrnd_pipe.sv
// Two-stage significand rounder with valid/ready flow control.
// Optional feature: SIGRND_RMM_EN (round-to-nearest ties-away on rm=100).
module sigrnd_pipe
  import fpu_rnd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sigrnd_pipe_if.slave       bus
);

  logic [SIG_W_D-1:0] kept;
  logic               r, st, inc1, inx1;
  logic [10:0]        exp_in;
  s1_t                s1_d, s1_q;
  logic               s1_v_q, s2_v_q;
  logic               adv, in_rdy;

  logic [SIG_W_D:0]   sum;
  logic               carry;
  logic [10:0]        emax;
  logic [SIG_W_D-1:0] f_d, f_q;
  logic [10:0]        e_d, e_q;
  logic               ovf2_d, ovf2_q, inx_q, tiny_q, ovf1_q;

  always_comb begin
    if (bus.db) begin
      kept   = bus.fn[127 -: SIG_W_D];
      r      = bus.fn[RND_D];
      st     = |bus.fn[RND_D-1:0];
      exp_in = bus.en;
    end else begin
      kept   = {{(SIG_W_D-SIG_W_S){1'b0}}, bus.fn[127 -: SIG_W_S]};
      r      = bus.fn[RND_S];
      st     = |bus.fn[RND_S-1:0];
      exp_in = {3'b000, bus.en[7:0]};
    end
  end

  rnd_decide u_dec (
    .lsb (kept[0]),
    .r   (r),
    .st  (st),
    .s   (bus.s),
    .rm  (rm_t'(bus.rm)),
    .inc (inc1),
    .inx (inx1)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.kept = kept;
    s1_d.inc  = inc1;
    s1_d.inx  = inx1;
    s1_d.exp  = exp_in;
    s1_d.db   = bus.db;
    s1_d.tiny = bus.tiny_in;
    s1_d.ovf1 = bus.ovf1_in;
  end

  // On carry-out the sum is exactly 2^W, so sum>>1 is the 1.000..0 pattern for either width.
  always_comb begin
    sum    = {1'b0, s1_q.kept} + {{SIG_W_D{1'b0}}, s1_q.inc};
    carry  = s1_q.db ? sum[SIG_W_D] : sum[SIG_W_S];
    emax   = s1_q.db ? 11'(EXP_MAX_D) : 11'(EXP_MAX_S);
    f_d    = carry ? sum[SIG_W_D:1] : sum[SIG_W_D-1:0];
    e_d    = s1_q.exp;
    if (carry) e_d = (s1_q.exp == emax) ? emax : s1_q.exp + 11'd1;
    ovf2_d = carry & (e_d == emax);
  end

  assign adv    = ~s2_v_q | bus.out_ready;
  assign in_rdy = ~s1_v_q | adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      f_q    <= '0;
      e_q    <= '0;
      inx_q  <= 1'b0;
      ovf2_q <= 1'b0;
      tiny_q <= 1'b0;
      ovf1_q <= 1'b0;
    end else begin
      if (in_rdy) begin
        s1_v_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          f_q    <= f_d;
          e_q    <= e_d;
          inx_q  <= s1_q.inx;
          ovf2_q <= ovf2_d;
          tiny_q <= s1_q.tiny;
          ovf1_q <= s1_q.ovf1;
        end
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_v_q;
  assign bus.f_out     = f_q;
  assign bus.e_out     = e_q;
  assign bus.inx       = inx_q;
  assign bus.ovf2      = ovf2_q;
  assign bus.tiny_out  = tiny_q;
  assign bus.ovf1_out  = ovf1_q;

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Self-checking bench for sigrnd_pipe: arithmetic reference model, directed and random beats.
module tb_sigrnd_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sigrnd_pipe_if bus();

  sigrnd_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SIGRND_RMM_EN
  localparam bit RMM_ON = 1'b1;
`else
  localparam bit RMM_ON = 1'b0;
`endif

  typedef struct {
    logic [52:0] f;
    logic [10:0] e;
    logic        inx;
    logic        ovf2;
    logic        tiny;
    logic        ovf1;
  } res_t;

  res_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rounding computed from the value: W kept bits, remainder compared against half an ulp.
  function automatic res_t model(input logic [127:0] fn, input logic [10:0] en, input logic s,
                                 input logic [2:0] rm, input logic db, input logic ti, input logic o1);
    res_t        o;
    int unsigned w, e0, emax, e;
    logic [54:0] kept, sum, lim;
    logic        r, st, inc;
    w    = db ? 53 : 24;
    kept = 55'(fn >> (128 - w));
    r    = fn[127 - w];
    st   = ((fn << (w + 1)) != 128'd0);
    if (rm == 3'd1)      inc = 1'b0;
    else if (rm == 3'd2) inc = !s && (r || st);
    else if (rm == 3'd3) inc = s && (r || st);
    else if (!r)         inc = 1'b0;
    else if (st)         inc = 1'b1;
    else if (rm == 3'd4 && RMM_ON) inc = 1'b1;
    else                 inc = kept[0];
    lim  = 55'd1 << w;
    sum  = kept + 55'(inc);
    e0   = db ? int'(en) : int'(en[7:0]);
    emax = db ? 2047 : 255;
    if (sum == lim) begin
      e      = (e0 + 1 > emax) ? emax : e0 + 1;
      o.f    = 53'(sum >> 1);
      o.e    = 11'(e);
      o.ovf2 = (e == emax);
    end else begin
      o.f    = 53'(sum);
      o.e    = 11'(e0);
      o.ovf2 = 1'b0;
    end
    o.inx  = r | st;
    o.tiny = ti;
    o.ovf1 = o1;
    return o;
  endfunction

  // Every cycle with out_valid high is compared against the head of the expected queue.
  always @(negedge clk) begin
    res_t x;
    if (rst) begin
      expq.delete();
    end else begin
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          x = expq[0];
          chk("f_out",    64'(bus.f_out),    64'(x.f));
          chk("e_out",    64'(bus.e_out),    64'(x.e));
          chk("inx",      64'(bus.inx),      64'(x.inx));
          chk("ovf2",     64'(bus.ovf2),     64'(x.ovf2));
          chk("tiny_out", 64'(bus.tiny_out), 64'(x.tiny));
          chk("ovf1_out", 64'(bus.ovf1_out), 64'(x.ovf1));
          if (bus.out_ready) begin
            void'(expq.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model(bus.fn, bus.en, bus.s, bus.rm, bus.db, bus.tiny_in, bus.ovf1_in));
    end
  end

  task automatic set_fields(input logic [127:0] fn, input logic [10:0] en, input logic s,
                            input logic [2:0] rm, input logic db);
    bus.fn      = fn;
    bus.en      = en;
    bus.s       = s;
    bus.rm      = rm;
    bus.db      = db;
    bus.tiny_in = 1'($urandom_range(0, 1));
    bus.ovf1_in = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_fields();
    logic [127:0] fn;
    logic [10:0]  en;
    logic         db;
    db = 1'($urandom_range(0, 1));
    fn = {$urandom, $urandom, $urandom, $urandom};
    en = 11'($urandom_range(0, 2047));
    if ($urandom_range(0, 3) == 0) begin
      if (db) fn[127:75] = '1;
      else    fn[127:104] = '1;
    end
    if ($urandom_range(0, 3) == 0) begin
      if (db) begin fn[74] = 1'b1;  fn[73:0]  = '0; end
      else    begin fn[103] = 1'b1; fn[102:0] = '0; end
    end
    if ($urandom_range(0, 3) == 0) en[7:0] = 8'(253 + $urandom_range(0, 2));
    if (db && $urandom_range(0, 3) == 0) en = 11'(2045 + $urandom_range(0, 2));
    set_fields(fn, en, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), db);
  endtask

  // One beat on an idle pipe with literal expectations and a latency-2 check.
  task automatic run_one(input string name, input logic [127:0] fn, input logic [10:0] en,
                         input logic s, input logic [2:0] rm, input logic db,
                         input logic [52:0] ef, input logic [10:0] ee,
                         input logic einx, input logic eovf2);
    int k;
    bus.out_ready = 1'b1;
    set_fields(fn, en, s, rm, db);
    bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin @(negedge clk); k++; end
    chk({name, "_accept"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!bus.out_valid && k < 10) begin @(negedge clk); k++; end
    chk({name, "_latency"}, 64'(k), 64'd2);
    chk({name, "_f"},    64'(bus.f_out), 64'(ef));
    chk({name, "_e"},    64'(bus.e_out), 64'(ee));
    chk({name, "_inx"},  64'(bus.inx),   64'(einx));
    chk({name, "_ovf2"}, 64'(bus.ovf2),  64'(eovf2));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, k;
    bit took;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_fields('0, '0, 1'b0, 3'd0, 1'b0);
    bus.tiny_in = 1'b0;
    bus.ovf1_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
    chk("reset_f_out",     64'(bus.f_out),     64'd0);
    chk("reset_e_out",     64'(bus.e_out),     64'd0);
    @(posedge clk);
    #1;

    run_one("rne_tie_even", {1'b1, 52'h0, 1'b1, 74'h0}, 11'd1023, 1'b0, 3'd0, 1'b1,
            53'h10000000000000, 11'd1023, 1'b1, 1'b0);
    run_one("rne_carry_ovf", {53'h1FFFFFFFFFFFFF, 1'b1, 74'h0}, 11'd2046, 1'b0, 3'd0, 1'b1,
            53'h10000000000000, 11'd2047, 1'b1, 1'b1);
    run_one("rz_trunc", {53'h1FFFFFFFFFFFFF, 1'b1, 74'h0}, 11'd2046, 1'b0, 3'd1, 1'b1,
            53'h1FFFFFFFFFFFFF, 11'd2046, 1'b1, 1'b0);
    run_one("sat_2047", {53'h1FFFFFFFFFFFFF, 1'b1, 74'h0}, 11'd2047, 1'b0, 3'd0, 1'b1,
            53'h10000000000000, 11'd2047, 1'b1, 1'b1);
    run_one("single_ru_pos", {24'hFFFFFF, 1'b0, 103'h1}, 11'd100, 1'b0, 3'd2, 1'b0,
            53'h800000, 11'd101, 1'b1, 1'b0);
    run_one("single_ru_neg", {24'hFFFFFF, 1'b0, 103'h1}, 11'd100, 1'b1, 3'd2, 1'b0,
            53'hFFFFFF, 11'd100, 1'b1, 1'b0);
    run_one("single_denorm", {24'h7FFFFF, 1'b1, 103'h0}, 11'h703, 1'b0, 3'd0, 1'b0,
            53'h800000, 11'd3, 1'b1, 1'b0);
    run_one("rm111_as_rne", {53'h3, 1'b1, 74'h0}, 11'd10, 1'b0, 3'd7, 1'b1,
            53'h4, 11'd10, 1'b1, 1'b0);
    run_one("rm100_tie", {53'h2, 1'b1, 74'h0}, 11'd5, 1'b0, 3'd4, 1'b1,
            RMM_ON ? 53'h3 : 53'h2, 11'd5, 1'b1, 1'b0);
    run_one("rd_exact", {53'h10000000000005, 75'h0}, 11'd7, 1'b1, 3'd3, 1'b1,
            53'h10000000000005, 11'd7, 1'b0, 1'b0);

    // Backpressure: 4 beats offered while the consumer stalls for 5 cycles.
    n0 = n_out;
    acc = 0;
    bus.out_ready = 1'b0;
    rand_fields();
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (acc < 4);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (c == 4) chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      if (took) begin acc++; rand_fields(); end
    end
    chk("bp_buffered", 64'(acc), 64'd2);
    bus.out_ready = 1'b1;
    k = 0;
    while (acc < 4 && k < 50) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      if (took) begin acc++; rand_fields(); end
      k++;
    end
    bus.in_valid = 1'b0;
    k = 0;
    while (expq.size() != 0 && k < 50) begin @(posedge clk); k++; end
    #1;
    chk("bp_beats_out", 64'(n_out - n0), 64'd4);

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    rand_fields();
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_mid_outs", 64'({bus.f_out, bus.e_out, bus.inx, bus.ovf2, bus.tiny_out, bus.ovf1_out}), 64'd0);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_one("post_rst", {1'b1, 52'h0, 1'b1, 74'h1}, 11'd200, 1'b0, 3'd0, 1'b1,
            53'h10000000000001, 11'd200, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    rand_fields();
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (took) rand_fields();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 50) begin @(posedge clk); k++; end
    #1;
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
